// File: rtl/burst_reorder_buffer_pkg.sv
// Shared encodings for the burst reorder buffer: replay modes, FSM states and
// the read-pointer seed used when a burst starts draining.
package burst_pkg;
   localparam logic MODE_LIFO = 1'b0;
   localparam logic MODE_FIFO = 1'b1;

   typedef enum logic {
      ST_LOAD  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   // FIFO replays from the oldest slot, LIFO from the newest one.
   function automatic logic [31:0] init_rd_ptr(input logic mode, input logic [31:0] cnt);
      return (mode == MODE_FIFO) ? 32'd0 : cnt - 32'd1;
   endfunction
endpackage

// File: rtl/burst_reorder_buffer_mem.sv
// Register file for one burst: one synchronous write port and one registered
// read port. Contents are deliberately left unreset.
module reorder_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_reg;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_data_reg <= mem[rd_addr];
   end

   assign rd_data = rd_data_reg;
endmodule

// File: rtl/burst_reorder_buffer.sv
// Captures a burst of words, then replays it reversed (LIFO) or in arrival
// order (FIFO), pausing replay while the downstream consumer is busy.
module burst_reorder_buffer
   import burst_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int CNT_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] din,
   output logic              i_ready,
   input  logic              mode,
   input  logic              busy,
   output logic              o_valid,
   output logic [DATA_W-1:0] dout,
   output logic [CNT_W-1:0]  count,
   output logic              drop
);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   state_t            state_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [ADDR_W-1:0] wr_ptr_reg;
   logic [ADDR_W-1:0] rd_ptr_reg;
   logic              mode_q_reg;
   logic              o_valid_reg;
   logic              drop_reg;
   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;

   assign i_ready = (state_reg == ST_LOAD) && (count_reg < FULL);
   assign wr_en   = i_valid && i_ready;
   assign rd_en   = (state_reg == ST_DRAIN) && !busy && (count_reg != '0);

   reorder_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_reg),
      .wr_data (din),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr_reg),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_LOAD;
         count_reg   <= '0;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         mode_q_reg  <= MODE_LIFO;
         o_valid_reg <= 1'b0;
         drop_reg    <= 1'b0;
      end else begin
         drop_reg <= 1'b0;
         case (state_reg)
            ST_LOAD: begin
               o_valid_reg <= 1'b0;
               if (wr_en) begin
                  wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
                  count_reg  <= count_reg + CNT_W'(1);
               end
               if (i_valid && count_reg == FULL)
                  drop_reg <= 1'b1;
               // A burst ends on the first idle input cycle with the consumer free.
               if (count_reg != '0 && !i_valid && !busy) begin
                  state_reg  <= ST_DRAIN;
                  mode_q_reg <= mode;
                  rd_ptr_reg <= ADDR_W'(init_rd_ptr(mode, 32'(count_reg)));
               end
            end
            ST_DRAIN: begin
               drop_reg <= i_valid;
               if (count_reg == '0) begin
                  state_reg   <= ST_LOAD;
                  o_valid_reg <= 1'b0;
                  wr_ptr_reg  <= '0;
               end else if (busy) begin
                  o_valid_reg <= 1'b0;
               end else begin
                  o_valid_reg <= 1'b1;
                  count_reg   <= count_reg - CNT_W'(1);
                  if (mode_q_reg == MODE_FIFO)
                     rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
                  else
                     rd_ptr_reg <= rd_ptr_reg - ADDR_W'(1);
               end
            end
            default: state_reg <= ST_LOAD;
         endcase
      end
   end

   // The read register is only meaningful alongside o_valid; mask it otherwise.
   assign dout    = o_valid_reg ? rd_data : '0;
   assign o_valid = o_valid_reg;
   assign count   = count_reg;
   assign drop    = drop_reg;
endmodule

// File: tb/tb_burst_reorder_buffer.sv
// Directed and randomized checks of burst_reorder_buffer against a queue-based
// model of burst capture and replay.
module tb_burst_reorder_buffer;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              i_valid = 1'b0;
   logic [DATA_W-1:0] din = '0;
   logic              i_ready;
   logic              mode = 1'b0;
   logic              busy = 1'b0;
   logic              o_valid;
   logic [DATA_W-1:0] dout;
   logic [CNT_W-1:0]  count;
   logic              drop;

   int total = 0;
   int bad   = 0;

   // Reference model: words held during capture, words still to replay.
   bit         m_draining = 0;
   logic [7:0] held[$];
   logic [7:0] pend[$];
   logic       m_ov = 0;
   logic [7:0] m_dout = 0;
   logic       m_drop = 0;
   int         m_count = 0;
   logic [7:0] obs[$];

   burst_reorder_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .i_valid (i_valid),
      .din     (din),
      .i_ready (i_ready),
      .mode    (mode),
      .busy    (busy),
      .o_valid (o_valid),
      .dout    (dout),
      .count   (count),
      .drop    (drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic model_edge();
      if (reset) begin
         m_draining = 0;
         held.delete();
         pend.delete();
         m_ov = 0; m_dout = 0; m_drop = 0;
      end else if (!m_draining) begin
         m_ov = 0; m_dout = 0; m_drop = 0;
         if (i_valid) begin
            if (held.size() < DEPTH) held.push_back(din);
            else m_drop = 1;
         end else if (held.size() > 0 && !busy) begin
            m_draining = 1;
            pend.delete();
            foreach (held[k]) begin
               if (mode) pend.push_back(held[k]);
               else pend.push_front(held[k]);
            end
            held.delete();
         end
      end else begin
         m_drop = i_valid;
         if (pend.size() == 0) begin
            m_draining = 0;
            m_ov = 0; m_dout = 0;
         end else if (busy) begin
            m_ov = 0; m_dout = 0;
         end else begin
            m_ov = 1;
            m_dout = pend.pop_front();
         end
      end
      m_count = m_draining ? pend.size() : held.size();
   endtask

   // One clock: update model from the inputs seen at the edge, then compare.
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("o_valid", 32'(o_valid), 32'(m_ov));
      check("dout", 32'(dout), 32'(m_dout));
      check("count", 32'(count), 32'(m_count));
      check("drop", 32'(drop), 32'(m_drop));
      check("i_ready", 32'(i_ready), 32'(!m_draining && held.size() < DEPTH));
      if (o_valid) begin
         obs.push_back(dout);
         $display("out dout=%02h count=%0d", dout, count);
      end
   endtask

   task automatic push(input logic [7:0] w);
      i_valid = 1'b1;
      din = w;
      step();
      i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      logic [7:0] words[4];
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;

      // Reset state
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      check("reset_count", 32'(count), 32'd0);
      check("reset_ready", 32'(i_ready), 32'd1);

      // LIFO basic
      mode = 1'b0; obs.delete();
      for (int k = 0; k < 4; k++) push(words[k]);
      step();
      check("lifo_latency_ov0", 32'(o_valid), 32'd0);
      step();
      check("lifo_latency_ov1", 32'(o_valid), 32'd1);
      idle(6);
      check("lifo_len", obs.size(), 32'd4);
      for (int k = 0; k < 4 && k < obs.size(); k++)
         check("lifo_word", 32'(obs[k]), 32'(words[3-k]));

      // FIFO basic, mode toggled mid-drain
      mode = 1'b1; obs.delete();
      for (int k = 0; k < 4; k++) push(words[k]);
      idle(3);
      mode = 1'b0;
      idle(5);
      check("fifo_len", obs.size(), 32'd4);
      for (int k = 0; k < 4 && k < obs.size(); k++)
         check("fifo_word", 32'(obs[k]), 32'(words[k]));

      // Backpressure after first output
      mode = 1'b0; obs.delete();
      push(8'hA1); push(8'hA2); push(8'hA3);
      idle(2);
      busy = 1'b1;
      idle(2);
      busy = 1'b0;
      idle(5);
      check("bp_len", obs.size(), 32'd3);
      if (obs.size() == 3) begin
         check("bp_w0", 32'(obs[0]), 32'hA3);
         check("bp_w2", 32'(obs[2]), 32'hA1);
      end

      // Busy at drain entry holds LOAD
      push(8'h5C);
      busy = 1'b1;
      idle(3);
      check("bp_entry_ready", 32'(i_ready), 32'd1);
      busy = 1'b0;
      idle(4);

      // Full burst plus overflow
      mode = 1'b0; obs.delete();
      for (int k = 0; k < DEPTH + 2; k++) push(8'(k));
      idle(DEPTH + 4);
      check("full_len", obs.size(), 32'(DEPTH));
      for (int k = 0; k < DEPTH && k < obs.size(); k++)
         check("full_word", 32'(obs[k]), 32'(DEPTH - 1 - k));

      // Input during drain is dropped
      obs.delete();
      push(8'h01); push(8'h02); push(8'h03);
      idle(2);
      i_valid = 1'b1; din = 8'hAA;
      step();
      i_valid = 1'b0;
      check("drain_drop", 32'(drop), 32'd1);
      idle(5);
      check("drain_count", 32'(count), 32'd0);
      foreach (obs[k]) check("no_aa", 32'(obs[k] == 8'hAA), 32'd0);

      // Reset mid-drain
      obs.delete();
      for (int k = 0; k < 5; k++) push(8'(8'h60 + k));
      idle(3);
      check("pre_reset_outs", obs.size(), 32'd2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("post_reset_ov", 32'(o_valid), 32'd0);
      check("post_reset_ready", 32'(i_ready), 32'd1);
      obs.delete();
      push(8'h5A);
      idle(4);
      check("post_reset_len", obs.size(), 32'd1);
      if (obs.size() == 1) check("post_reset_word", 32'(obs[0]), 32'h5A);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         i_valid = ($urandom_range(0, 2) == 0);
         din     = 8'($urandom);
         busy    = ($urandom_range(0, 3) == 0);
         mode    = 1'($urandom);
         reset   = ($urandom_range(0, 99) == 0);
         step();
      end
      reset = 1'b0; i_valid = 1'b0; busy = 1'b0;
      idle(DEPTH + 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
